// File: rtl/lfsr_checker.sv
// lfsr_checker: receive-side PRBS checker for the modem test path.
// Rebuilds the 15-bit stimulus LFSR, hunts for the channel symbol delay across
// a small delay line of expected symbols, then counts symbol bit errors while
// locked, latching the total once per measurement window.
// Optional build macro: LFSR_CHECKER_ERR_INJECT_EN adds the err_inject input,
// which inverts rx_sym[0] on a strobe before the comparison.
module lfsr_checker #(
  parameter int MAX_DELAY   = 8,
  parameter int LOCK_THRESH = 32,
  parameter int LOSS_THRESH = 8,
  parameter int WINDOW      = 2048
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         sym_clk_ena,
  input  logic [1:0]                   rx_sym,
`ifdef LFSR_CHECKER_ERR_INJECT_EN
  input  logic                         err_inject,
`endif
  output logic                         locked,
  output logic [$clog2(MAX_DELAY)-1:0] tap_sel,
  output logic                         sym_err,
  output logic                         window_done,
  output logic [15:0]                  bit_err_count
);

  localparam int TW = $clog2(MAX_DELAY);
  localparam int GW = $clog2(LOCK_THRESH + 1);
  localparam int BW = $clog2(LOSS_THRESH + 1);
  localparam int WW = $clog2(WINDOW);

  localparam logic [TW-1:0] TAP_LAST  = TW'(MAX_DELAY - 1);
  localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_THRESH - 1);
  localparam logic [BW-1:0] BAD_LAST  = BW'(LOSS_THRESH - 1);
  localparam logic [WW-1:0] WIN_LAST  = WW'(WINDOW - 1);

  typedef enum logic {ST_HUNT, ST_LOCKED} state_t;

  state_t                      state_q, state_d;
  logic [14:0]                 r_q, r_d;
  logic [MAX_DELAY-1:0][1:0]   pipe_q, pipe_d;
  logic [TW-1:0]               tap_q, tap_d;
  logic [GW-1:0]               good_q, good_d;
  logic [BW-1:0]               bad_q, bad_d;
  logic [WW-1:0]               win_q, win_d;
  logic [15:0]                 acc_q, acc_d;
  logic [15:0]                 bec_q, bec_d;
  logic                        sym_err_q, sym_err_d;
  logic                        wd_q, wd_d;

  logic [1:0]                  rx_eff;
  logic [1:0]                  diff;
  logic [1:0]                  nerr;
  logic [1:0]                  add_err;
  logic [16:0]                 acc_sum;
  logic [15:0]                 acc_sat;
  logic [TW-1:0]               tap_next;

  // Next-state: replica stepping, delay line, hunt/lock FSM and window accounting
  always_comb begin
    r_d       = {r_q[0] ^ r_q[14], r_q[14:1]};
    pipe_d    = pipe_q;
    state_d   = state_q;
    tap_d     = tap_q;
    good_d    = good_q;
    bad_d     = bad_q;
    win_d     = win_q;
    acc_d     = acc_q;
    bec_d     = bec_q;
    sym_err_d = 1'b0;
    wd_d      = 1'b0;
    add_err   = 2'd0;

    rx_eff = rx_sym;
`ifdef LFSR_CHECKER_ERR_INJECT_EN
    rx_eff[0] = rx_sym[0] ^ err_inject;
`endif
    // Compare against the delay line before this strobe's shift
    diff     = rx_eff ^ pipe_q[tap_q];
    nerr     = {1'b0, diff[1]} + {1'b0, diff[0]};
    tap_next = (tap_q == TAP_LAST) ? '0 : tap_q + TW'(1);

    if (sym_clk_ena) begin
      pipe_d[0] = r_q[1:0];
      for (int i = 1; i < MAX_DELAY; i++) pipe_d[i] = pipe_q[i-1];

      case (state_q)
        ST_HUNT: begin
          if (diff == 2'b00) begin
            good_d = good_q + GW'(1);
            if (good_q == GOOD_LAST) begin
              state_d = ST_LOCKED;
              bad_d   = '0;
            end
          end else begin
            good_d = '0;
            tap_d  = tap_next;
          end
        end
        ST_LOCKED: begin
          if (diff != 2'b00) begin
            sym_err_d = 1'b1;
            add_err   = nerr;
            bad_d     = bad_q + BW'(1);
            if (bad_q == BAD_LAST) begin
              state_d = ST_HUNT;
              tap_d   = tap_next;
              good_d  = '0;
            end
          end else begin
            bad_d = '0;
          end
        end
        default: state_d = ST_HUNT;
      endcase

      // Errors of the terminal strobe still land in the latched count
      acc_sum = {1'b0, acc_q} + {15'd0, add_err};
      acc_sat = acc_sum[16] ? 16'hFFFF : acc_sum[15:0];
      if (win_q == WIN_LAST) begin
        bec_d = acc_sat;
        acc_d = '0;
        win_d = '0;
        wd_d  = 1'b1;
      end else begin
        acc_d = acc_sat;
        win_d = win_q + WW'(1);
      end
    end else begin
      acc_sum = 17'd0;
      acc_sat = 16'd0;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_HUNT;
      r_q       <= 15'h7FFF;
      pipe_q    <= '1;
      tap_q     <= '0;
      good_q    <= '0;
      bad_q     <= '0;
      win_q     <= '0;
      acc_q     <= '0;
      bec_q     <= '0;
      sym_err_q <= 1'b0;
      wd_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      r_q       <= r_d;
      pipe_q    <= pipe_d;
      tap_q     <= tap_d;
      good_q    <= good_d;
      bad_q     <= bad_d;
      win_q     <= win_d;
      acc_q     <= acc_d;
      bec_q     <= bec_d;
      sym_err_q <= sym_err_d;
      wd_q      <= wd_d;
    end
  end

  assign locked        = (state_q == ST_LOCKED);
  assign tap_sel       = tap_q;
  assign sym_err       = sym_err_q;
  assign window_done   = wd_q;
  assign bit_err_count = bec_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Bench for lfsr_checker: scenario table, hand-written window/loss/reset
// sequences and a randomized run, all checked every clk against a reference
// model built on a precomputed PRBS table and symbol history queues.
module tb_lfsr_checker;
  localparam int MAXD  = 8;
  localparam int LOCKT = 32;
  localparam int LOSST = 8;
  localparam int WIN   = 2048;
  localparam int NSEQ  = 32768;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stb = 1'b0;
  logic [1:0]  rx = 2'b11;
  logic        inj = 1'b0;
  logic        locked;
  logic [2:0]  tap;
  logic        sym_err;
  logic        wd;
  logic [15:0] bec;

  always #5 clk = ~clk;

  lfsr_checker #(.MAX_DELAY(MAXD), .LOCK_THRESH(LOCKT), .LOSS_THRESH(LOSST), .WINDOW(WIN)) dut (
    .clk(clk),
    .reset(reset),
    .sym_clk_ena(stb),
    .rx_sym(rx),
`ifdef LFSR_CHECKER_ERR_INJECT_EN
    .err_inject(inj),
`endif
    .locked(locked),
    .tap_sel(tap),
    .sym_err(sym_err),
    .window_done(wd),
    .bit_err_count(bec)
  );

  // PRBS state as a function of clks since reset
  logic [14:0] seq [NSEQ];

  int n_vec = 0;
  int n_bad = 0;

  // reference model
  int         m_t;
  bit         m_locked;
  int         m_tap, m_good, m_bad, m_win, m_acc, m_bec;
  bit         m_serr, m_wd;
  logic [1:0] hist[$];
  logic [1:0] line[$];
  int         chan_d = 0;
  int         serr_seen, wd_seen;

  typedef struct {
    int   dly;
    int   nstb;
    int   inv_from;
    int   flip_at;
    logic exp_lock;
    int   exp_tap;
    int   exp_serr;
  } vec_t;
  vec_t tbl[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic line_reset();
    line = {};
    repeat (chan_d + 1) line.push_back(2'b11);
  endtask

  task automatic model_reset();
    m_t = 0; m_locked = 0; m_tap = 0; m_good = 0; m_bad = 0;
    m_win = 0; m_acc = 0; m_bec = 0; m_serr = 0; m_wd = 0;
    hist = {};
    repeat (MAXD) hist.push_back(2'b11);
  endtask

  task automatic model_step();
    logic [1:0] d;
    int ne, add;
    if (!reset) begin
      model_reset();
      return;
    end
    m_serr = 0;
    m_wd   = 0;
    if (stb) begin
      d = rx ^ hist[m_tap];
`ifdef LFSR_CHECKER_ERR_INJECT_EN
      if (inj) d[0] = ~d[0];
`endif
      ne  = int'(d[0]) + int'(d[1]);
      add = 0;
      if (!m_locked) begin
        if (ne == 0) begin
          m_good++;
          if (m_good == LOCKT) begin m_locked = 1; m_bad = 0; end
        end else begin
          m_good = 0;
          m_tap  = (m_tap + 1) % MAXD;
        end
      end else if (ne != 0) begin
        m_serr = 1;
        add    = ne;
        m_bad++;
        if (m_bad == LOSST) begin
          m_locked = 0;
          m_tap    = (m_tap + 1) % MAXD;
          m_good   = 0;
        end
      end else begin
        m_bad = 0;
      end
      m_acc = (m_acc + add > 65535) ? 65535 : m_acc + add;
      m_win++;
      if (m_win == WIN) begin
        m_bec = m_acc; m_acc = 0; m_win = 0; m_wd = 1;
      end
      hist.push_front(seq[m_t][1:0]);
      void'(hist.pop_back());
    end
    m_t++;
    if (m_t >= NSEQ) begin
      $display("FAIL seq_range: got %0d, want below %0d", m_t, NSEQ);
      $fatal(1, "PRBS table exhausted");
    end
  endtask

  task automatic tick();
    int te;
    @(posedge clk);
    te = m_t;
    model_step();
    if (!reset) line_reset();
    else if (stb) begin
      line.push_front(seq[te][1:0]);
      void'(line.pop_back());
    end
    #1;
    if (sym_err === 1'b1) serr_seen++;
    if (wd === 1'b1) wd_seen++;
    chk("locked", locked, m_locked);
    chk("tap_sel", tap, m_tap);
    chk("sym_err", sym_err, m_serr);
    chk("window_done", wd, m_wd);
    chk("bit_err_count", bec, m_bec);
  endtask

  task automatic strobe(input logic [1:0] xm, input int gap);
    stb = 1'b0;
    repeat (gap) tick();
    stb = 1'b1;
    rx  = line[$] ^ xm;
    tick();
    stb = 1'b0;
    inj = 1'b0;
  endtask

  task automatic do_reset();
    stb   = 1'b0;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    serr_seen = 0;
    wd_seen   = 0;
  endtask

  initial begin
    int burst;
    logic [1:0] xm;

    seq[0] = 15'h7FFF;
    for (int i = 1; i < NSEQ; i++) seq[i] = {seq[i-1][0] ^ seq[i-1][14], seq[i-1][14:1]};

    tbl[0] = '{0,  31, -1, -1, 1'b0, 0, 0};
    tbl[1] = '{0,  32, -1, -1, 1'b1, 0, 0};
    tbl[2] = '{3, 288, -1, -1, 1'b1, 3, 0};
    tbl[3] = '{6, 300, -1, -1, 1'b1, 6, 0};
    tbl[4] = '{0,  36, -1, 34, 1'b1, 0, 1};
    tbl[5] = '{0,  39, 33, -1, 1'b1, 0, 7};
    tbl[6] = '{0,  40, 33, -1, 1'b0, 1, 8};

    // reset state
    chan_d = 0;
    do_reset();
    chk("rst_locked", locked, 0);
    chk("rst_tap", tap, 0);
    chk("rst_bec", bec, 0);

    // scenario table: lock timing, channel delays, injected error, loss of lock
    for (int i = 0; i < 7; i++) begin
      chan_d = tbl[i].dly;
      do_reset();
      for (int k = 1; k <= tbl[i].nstb; k++) begin
        xm = 2'b00;
        if (tbl[i].inv_from > 0 && k >= tbl[i].inv_from) xm = 2'b11;
        if (k == tbl[i].flip_at) xm = 2'b01;
        strobe(xm, 3);
      end
      chk($sformatf("tbl%0d_locked", i), locked, tbl[i].exp_lock);
      chk($sformatf("tbl%0d_tap", i), tap, tbl[i].exp_tap);
      chk($sformatf("tbl%0d_sym_err_pulses", i), serr_seen, tbl[i].exp_serr);
    end

    // clean first window, then one injected error in the second
    chan_d = 0;
    do_reset();
    repeat (WIN) strobe(2'b00, 3);
    chk("win1_done", wd, 1);
    chk("win1_count", bec, 0);
    chk("win1_pulses", wd_seen, 1);
    serr_seen = 0;
    for (int k = WIN + 1; k <= 2 * WIN; k++) strobe((k == 3000) ? 2'b01 : 2'b00, 3);
    chk("win2_done", wd, 1);
    chk("win2_count", bec, 1);
    chk("win2_locked", locked, 1);
    chk("win2_sym_err_pulses", serr_seen, 1);

    // inverted burst straddling the window end: 4 errored strobes x 2 bits latched
    do_reset();
    for (int k = 1; k <= WIN + 4; k++) begin
      strobe((k >= WIN - 3) ? 2'b11 : 2'b00, 3);
      if (k == WIN) begin
        chk("burst_win_done", wd, 1);
        chk("burst_win_count", bec, 8);
        chk("burst_win_locked", locked, 1);
      end
    end
    chk("burst_locked", locked, 0);
    chk("burst_tap", tap, 1);
    chk("burst_sym_err_pulses", serr_seen, 8);

    // reset while locked mid-window, then relock with identical timing
    do_reset();
    repeat (1000) strobe(2'b00, 3);
    chk("mid_locked", locked, 1);
    do_reset();
    chk("mrst_locked", locked, 0);
    chk("mrst_tap", tap, 0);
    chk("mrst_sym_err", sym_err, 0);
    chk("mrst_wd", wd, 0);
    chk("mrst_bec", bec, 0);
    repeat (LOCKT - 1) strobe(2'b00, 3);
    chk("relock_early", locked, 0);
    strobe(2'b00, 3);
    chk("relock_locked", locked, 1);
    chk("relock_tap", tap, 0);

    // randomized: gaps, sparse symbol errors, inverted bursts, injections, resets
    chan_d = $urandom_range(0, 4);
    do_reset();
    burst = 0;
    for (int k = 0; k < 2500; k++) begin
      xm = 2'b00;
      if (burst > 0) begin
        xm = 2'b11;
        burst--;
      end else if ($urandom_range(0, 199) == 0) begin
        burst = $urandom_range(3, 12);
      end else if ($urandom_range(0, 9) == 0) begin
        xm = 2'($urandom);
      end
`ifdef LFSR_CHECKER_ERR_INJECT_EN
      inj = ($urandom_range(0, 19) == 0);
`endif
      strobe(xm, $urandom_range(1, 5));
      if ($urandom_range(0, 799) == 0) do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
